// File: rtl/fetch_request_unit.sv
// Purpose: PC generator and i-cache request issuer feeding the instruction queue.
// Latency: requests come straight from registered pc; responses pass through to the queue with 0 latency.
// Backpressure: req_valid is held until req_ready; queue space is tracked with credits returned by q_deq.
module fetch_request_unit #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          QUEUE_DEPTH     = 8,
    parameter int          MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [31:0] req_pc,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_data,
    input  logic [31:0] rsp_pc,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic [31:0] out_pc,
    input  logic        q_deq,
    output logic        q_flush,
    output logic        proto_err
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW = $clog2(QUEUE_DEPTH + 1);
    localparam logic [OW-1:0] OUT_MAX  = OW'(MAX_OUTSTANDING);
    localparam logic [CW-1:0] CRED_MAX = CW'(QUEUE_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [OW-1:0] outst_q, outst_d;
    logic [CW-1:0] cred_q, cred_d;
    logic          perr_q, perr_d;

    logic active;    // redirect is honoured only outside IDLE
    logic redir;
    logic rsp_ok;    // response that matches an in-flight request
    logic hs;        // request handshake

    // State register; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            outst_q <= '0;
            cred_q  <= CRED_MAX;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            outst_q <= outst_d;
            cred_q  <= cred_d;
            perr_q  <= perr_d;
        end
    end

    // Next-state and output logic: request issue, response forwarding, credit and redirect handling.
    always_comb begin
        active    = (state_q != IDLE);
        redir     = redirect_valid && active;
        rsp_ok    = rsp_valid && (outst_q != '0);
        req_valid = (state_q == RUN) && (cred_q != '0) && (outst_q != OUT_MAX) && !redirect_valid;
        hs        = req_valid && req_ready;
        out_valid = rsp_ok && (state_q == RUN) && !redirect_valid;
        q_flush   = redir;

        // A response with nothing in flight is dropped and latched as a protocol error.
        perr_d = perr_q || (rsp_valid && (outst_q == '0));

        outst_d = outst_q;
        if (hs && !rsp_ok) begin
            outst_d = outst_q + OW'(1);
        end else if (!hs && rsp_ok) begin
            outst_d = outst_q - OW'(1);
        end

        pc_d    = pc_q;
        cred_d  = cred_q;
        state_d = state_q;

        if (!active) begin
            // One bubble after reset before fetching starts.
            state_d = RUN;
        end else if (redir) begin
            // Queue is flushed this cycle, so all credits come back and any q_deq is moot.
            pc_d    = redirect_pc;
            cred_d  = CRED_MAX;
            state_d = (outst_d != '0) ? DRAIN : RUN;
        end else begin
            if (hs) begin
                pc_d = pc_q + 32'd4;
            end
            if (q_deq && !hs && (cred_q != CRED_MAX)) begin
                cred_d = cred_q + CW'(1);
            end else if (hs && !q_deq) begin
                cred_d = cred_q - CW'(1);
            end
            if ((state_q == DRAIN) && (outst_d == '0)) begin
                state_d = RUN;
            end
        end
    end

    assign req_pc    = pc_q;
    assign out_data  = rsp_data;
    assign out_pc    = rsp_pc;
    assign proto_err = perr_q;

endmodule
